// File: rtl/star_bound_mapper_if.sv
// Handshake/bus bundle between the scan FSM, image RAM and the star bound mapper.
// The master side issues go requests, seeds and RAM data; the slave side is the mapper.
interface star_bound_mapper_if #(
    parameter int xSz    = 8,
    parameter int ySz    = 7,
    parameter int addrSz = 15,
    parameter int colSz  = 3
);
    logic              goMapRows;
    logic              goMapColumnsL;
    logic              goMapColumnsR;
    logic [xSz-1:0]    xSeed;
    logic [ySz-1:0]    ySeed;
    logic [colSz-1:0]  pixVal;
    logic [addrSz-1:0] rdAddr;
    logic              rdEn;
    logic [ySz-1:0]    yTop;
    logic [ySz-1:0]    yBottom;
    logic [xSz-1:0]    xLeft;
    logic [xSz-1:0]    xRight;
    logic              topBottomFound;
    logic              leftFound;
    logic              rightFound;
    logic              busy;

    modport master (
        output goMapRows, goMapColumnsL, goMapColumnsR, xSeed, ySeed, pixVal,
        input  rdAddr, rdEn, yTop, yBottom, xLeft, xRight,
               topBottomFound, leftFound, rightFound, busy
    );

    modport slave (
        input  goMapRows, goMapColumnsL, goMapColumnsR, xSeed, ySeed, pixVal,
        output rdAddr, rdEn, yTop, yBottom, xLeft, xRight,
               topBottomFound, leftFound, rightFound, busy
    );
endinterface

// File: rtl/star_bound_mapper.sv
// Probes image RAM outward from a seed pixel and returns the star's bounding box.
// Each probe costs three cycles (ISSUE/WAIT/EVAL); the found pulse is decoded from DONE.
//
// state | meaning
// IDLE  | waiting for a go request
// ISSUE | drive probe address to RAM
// WAIT  | RAM read in flight, address held
// EVAL  | pixVal valid: lit extends the bound, dark ends the scan
// DONE  | one-cycle found pulse for the active mode
module star_bound_mapper #(
    parameter int xSz       = 8,
    parameter int ySz       = 7,
    parameter int addrSz    = 15,
    parameter int colSz     = 3,
    parameter int MAX_X     = 160,
    parameter int MAX_Y     = 120,
    parameter int THRESHOLD = 0
) (
    input  logic               clk,
    input  logic               resetn,
    star_bound_mapper_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;
    typedef enum logic [1:0] {M_ROW, M_LEFT, M_RIGHT} mode_t;

    localparam logic [ySz:0]     Y_LIM = (ySz+1)'(MAX_Y);
    localparam logic [xSz:0]     X_LIM = (xSz+1)'(MAX_X);
    localparam logic [xSz-1:0]   X_ONE = xSz'(1);
    localparam logic [colSz-1:0] THR   = colSz'(THRESHOLD);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [xSz-1:0]   x_seed_q, x_seed_d;
    logic [xSz-1:0]   cur_x_q, cur_x_d;
    logic [ySz-1:0]   cur_y_q, cur_y_d;
    logic [ySz-1:0]   y_top_q, y_top_d;
    logic [ySz-1:0]   y_bot_q, y_bot_d;
    logic [xSz-1:0]   x_left_q, x_left_d;
    logic [xSz-1:0]   x_right_q, x_right_d;

    logic [ySz:0]     y_sum;
    logic [ySz-1:0]   y_mid;
    logic [ySz:0]     y_seed_inc;
    logic [ySz:0]     cur_y_inc;
    logic [xSz:0]     x_seed_inc;
    logic [xSz:0]     cur_x_inc;
    logic             pix_lit;
    logic             probing;
    logic [addrSz-1:0] probe_addr;

    assign y_sum      = {1'b0, y_top_q} + {1'b0, y_bot_q};
    assign y_mid      = ySz'(y_sum >> 1);
    assign y_seed_inc = {1'b0, bus.ySeed} + (ySz+1)'(1);
    assign cur_y_inc  = {1'b0, cur_y_q} + (ySz+1)'(1);
    assign x_seed_inc = {1'b0, x_seed_q} + (xSz+1)'(1);
    assign cur_x_inc  = {1'b0, cur_x_q} + (xSz+1)'(1);
    assign pix_lit    = bus.pixVal > THR;

    // y*160 as y*128 + y*32 keeps the address path to two adders
    assign probe_addr = addrSz'({cur_y_q, 7'b0}) + addrSz'({cur_y_q, 5'b0}) + addrSz'(cur_x_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        x_seed_d  = x_seed_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        y_top_d   = y_top_q;
        y_bot_d   = y_bot_q;
        x_left_d  = x_left_q;
        x_right_d = x_right_q;
        case (state_q)
            S_IDLE: begin
                if (bus.goMapRows) begin
                    mode_d   = M_ROW;
                    x_seed_d = bus.xSeed;
                    y_top_d  = bus.ySeed;
                    y_bot_d  = bus.ySeed;
                    cur_x_d  = bus.xSeed;
                    cur_y_d  = y_seed_inc[ySz-1:0];
                    state_d  = (y_seed_inc >= Y_LIM) ? S_DONE : S_ISSUE;
                end else if (bus.goMapColumnsL) begin
                    mode_d   = M_LEFT;
                    x_left_d = x_seed_q;
                    cur_y_d  = y_mid;
                    cur_x_d  = x_seed_q - X_ONE;
                    state_d  = (x_seed_q == '0) ? S_DONE : S_ISSUE;
                end else if (bus.goMapColumnsR) begin
                    mode_d    = M_RIGHT;
                    x_right_d = x_seed_q;
                    cur_y_d   = y_mid;
                    cur_x_d   = x_seed_inc[xSz-1:0];
                    state_d   = (x_seed_inc >= X_LIM) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_EVAL;
            S_EVAL: begin
                if (!pix_lit) begin
                    state_d = S_DONE;
                end else begin
                    case (mode_q)
                        M_ROW: begin
                            y_bot_d = cur_y_q;
                            cur_y_d = cur_y_inc[ySz-1:0];
                            state_d = (cur_y_inc >= Y_LIM) ? S_DONE : S_ISSUE;
                        end
                        M_LEFT: begin
                            x_left_d = cur_x_q;
                            cur_x_d  = cur_x_q - X_ONE;
                            state_d  = (cur_x_q == '0) ? S_DONE : S_ISSUE;
                        end
                        M_RIGHT: begin
                            x_right_d = cur_x_q;
                            cur_x_d   = cur_x_inc[xSz-1:0];
                            state_d   = (cur_x_inc >= X_LIM) ? S_DONE : S_ISSUE;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            mode_q    <= M_ROW;
            x_seed_q  <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            y_top_q   <= '0;
            y_bot_q   <= '0;
            x_left_q  <= '0;
            x_right_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            x_seed_q  <= x_seed_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            y_top_q   <= y_top_d;
            y_bot_q   <= y_bot_d;
            x_left_q  <= x_left_d;
            x_right_q <= x_right_d;
        end
    end

    assign probing            = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_EVAL);
    assign bus.rdEn           = probing;
    assign bus.rdAddr         = probing ? probe_addr : '0;
    assign bus.yTop           = y_top_q;
    assign bus.yBottom        = y_bot_q;
    assign bus.xLeft          = x_left_q;
    assign bus.xRight         = x_right_q;
    assign bus.topBottomFound = (state_q == S_DONE) && (mode_q == M_ROW);
    assign bus.leftFound      = (state_q == S_DONE) && (mode_q == M_LEFT);
    assign bus.rightFound     = (state_q == S_DONE) && (mode_q == M_RIGHT);
    assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_star_bound_mapper.sv
// Bench for star_bound_mapper: image RAM model, scan-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized images and go traffic.
`timescale 1ns/1ps
module tb_star_bound_mapper;
    localparam int MAX_X = 160;
    localparam int MAX_Y = 120;
    localparam int NPIX  = MAX_X * MAX_Y;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    star_bound_mapper_if #(.xSz(8), .ySz(7), .addrSz(15), .colSz(3)) bus ();

    star_bound_mapper #(
        .xSz(8), .ySz(7), .addrSz(15), .colSz(3),
        .MAX_X(MAX_X), .MAX_Y(MAX_Y), .THRESHOLD(0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [2:0] mem [NPIX];
    int n_vec = 0;
    int n_bad = 0;
    int n_lf  = 0;
    int n_rf  = 0;

    // synchronous image RAM: data valid the cycle after the address is captured
    always @(posedge clk) begin
        int a;
        a = int'(bus.rdAddr);
        bus.pixVal <= (a < NPIX) ? mem[a] : 3'd0;
    end

    always @(negedge clk) begin
        if (bus.leftFound)  n_lf++;
        if (bus.rightFound) n_rf++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_lit(input int x, input int y);
        return mem[y * MAX_X + x] != 3'd0;
    endfunction

    // ---------------- reference model: whole-scan view ----------------
    bit m_active = 0;
    int m_k = 0, m_n = 0, m_nlit = 0, m_mode = 0;
    int m_addr[$];
    int m_ytop = 0, m_ybot = 0, m_xl = 0, m_xr = 0, m_xs = 0;

    always @(negedge clk) begin
        int pr, ym;
        int e_busy, e_en, e_addr, e_tb, e_l, e_r, e_ytop, e_ybot, e_xl, e_xr;
        if (!resetn) begin
            m_active = 0;
            m_ytop = 0; m_ybot = 0; m_xl = 0; m_xr = 0; m_xs = 0;
        end
        e_busy = 0; e_en = 0; e_addr = 0; e_tb = 0; e_l = 0; e_r = 0;
        e_ytop = m_ytop; e_ybot = m_ybot; e_xl = m_xl; e_xr = m_xr;
        if (m_active) begin
            e_busy = 1;
            pr = (m_k / 3 < m_nlit) ? m_k / 3 : m_nlit;
            case (m_mode)
                0:       e_ybot = m_ybot + pr;
                1:       e_xl   = m_xl - pr;
                default: e_xr   = m_xr + pr;
            endcase
            if (m_k < 3 * m_n) begin
                e_en   = 1;
                e_addr = m_addr[m_k / 3];
            end else begin
                e_tb = (m_mode == 0) ? 1 : 0;
                e_l  = (m_mode == 1) ? 1 : 0;
                e_r  = (m_mode == 2) ? 1 : 0;
            end
        end
        chk("busy",           int'(bus.busy),           e_busy);
        chk("rdEn",           int'(bus.rdEn),           e_en);
        chk("rdAddr",         int'(bus.rdAddr),         e_addr);
        chk("topBottomFound", int'(bus.topBottomFound), e_tb);
        chk("leftFound",      int'(bus.leftFound),      e_l);
        chk("rightFound",     int'(bus.rightFound),     e_r);
        chk("yTop",           int'(bus.yTop),           e_ytop);
        chk("yBottom",        int'(bus.yBottom),        e_ybot);
        chk("xLeft",          int'(bus.xLeft),          e_xl);
        chk("xRight",         int'(bus.xRight),         e_xr);

        if (resetn) begin
            if (m_active) begin
                if (m_k == 3 * m_n) begin
                    m_active = 0;
                    case (m_mode)
                        0:       m_ybot = m_ybot + m_nlit;
                        1:       m_xl   = m_xl - m_nlit;
                        default: m_xr   = m_xr + m_nlit;
                    endcase
                end else begin
                    m_k++;
                end
            end else if (bus.goMapRows || bus.goMapColumnsL || bus.goMapColumnsR) begin
                m_addr.delete();
                m_nlit   = 0;
                m_k      = 0;
                m_active = 1;
                ym = (m_ytop + m_ybot) / 2;
                if (bus.goMapRows) begin
                    m_mode = 0;
                    m_xs   = int'(bus.xSeed);
                    m_ytop = int'(bus.ySeed);
                    m_ybot = int'(bus.ySeed);
                    for (int y = m_ybot + 1; y < MAX_Y; y++) begin
                        m_addr.push_back(y * MAX_X + m_xs);
                        if (is_lit(m_xs, y)) m_nlit++;
                        else break;
                    end
                end else if (bus.goMapColumnsL) begin
                    m_mode = 1;
                    m_xl   = m_xs;
                    for (int x = m_xs - 1; x >= 0; x--) begin
                        m_addr.push_back(ym * MAX_X + x);
                        if (is_lit(x, ym)) m_nlit++;
                        else break;
                    end
                end else begin
                    m_mode = 2;
                    m_xr   = m_xs;
                    for (int x = m_xs + 1; x < MAX_X; x++) begin
                        m_addr.push_back(ym * MAX_X + x);
                        if (is_lit(x, ym)) m_nlit++;
                        else break;
                    end
                end
                m_n = m_addr.size();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 3'd0;
    endtask

    task automatic set_px(input int x, input int y, input int v);
        mem[y * MAX_X + x] = 3'(v);
    endtask

    // returns at posedge+1 of the cycle right after the acceptance edge
    task automatic go(input bit r, input bit l, input bit rr, input int xs, input int ys);
        @(posedge clk); #1;
        bus.goMapRows     = r;
        bus.goMapColumnsL = l;
        bus.goMapColumnsR = rr;
        bus.xSeed         = 8'(xs);
        bus.ySeed         = 7'(ys);
        @(posedge clk); #1;
        bus.goMapRows     = 1'b0;
        bus.goMapColumnsL = 1'b0;
        bus.goMapColumnsR = 1'b0;
    endtask

    task automatic wait_found(input int which, output int lat);
        lat = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ((which == 0 && bus.topBottomFound) || (which == 1 && bus.leftFound) ||
                (which == 2 && bus.rightFound)) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL found_timeout: no pulse for mode %0d within 2000 cycles", which);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!m_active) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL idle_timeout: scan still active after 2000 cycles");
        end
    endtask

    initial begin
        int lat, lf0, rf0, rw, rh, rx, ry;
        bus.goMapRows     = 1'b0;
        bus.goMapColumnsL = 1'b0;
        bus.goMapColumnsR = 1'b0;
        bus.xSeed         = '0;
        bus.ySeed         = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_yBottom", int'(bus.yBottom), 0);

        // single lit pixel: one dark probe below the seed
        set_px(10, 5, 3);
        go(1, 0, 0, 10, 5);
        wait_found(0, lat);
        chk("s1_latency", lat, 3);
        chk("s1_yTop", int'(bus.yTop), 5);
        chk("s1_yBottom", int'(bus.yBottom), 5);

        // 3x3 star x 20..22, y 40..42
        clear_mem();
        for (int y = 40; y <= 42; y++)
            for (int x = 20; x <= 22; x++) set_px(x, y, 7);
        go(1, 0, 0, 20, 40);
        wait_found(0, lat);
        chk("s2_rows_latency", lat, 9);
        chk("s2_yTop", int'(bus.yTop), 40);
        chk("s2_yBottom", int'(bus.yBottom), 42);
        go(0, 1, 0, 0, 0);
        wait_found(1, lat);
        chk("s2_left_latency", lat, 3);
        chk("s2_xLeft", int'(bus.xLeft), 20);
        go(0, 0, 1, 0, 0);
        wait_found(2, lat);
        chk("s2_right_latency", lat, 9);
        chk("s2_xRight", int'(bus.xRight), 22);

        // image edges: seed on bottom row, seed on left column
        clear_mem();
        for (int y = 117; y <= 119; y++) set_px(5, y, 1);
        set_px(0, 119, 2);
        go(1, 0, 0, 0, 119);
        wait_found(0, lat);
        chk("s3_rows_edge_latency", lat, 0);
        chk("s3_yBottom_edge", int'(bus.yBottom), 119);
        go(0, 1, 0, 0, 0);
        wait_found(1, lat);
        chk("s3_left_edge_latency", lat, 0);
        chk("s3_xLeft_edge", int'(bus.xLeft), 0);
        go(1, 0, 0, 5, 117);
        wait_found(0, lat);
        chk("s3_rows_to_edge_latency", lat, 6);
        chk("s3_yBottom_to_edge", int'(bus.yBottom), 119);

        // simultaneous gos and a go while busy
        clear_mem();
        for (int y = 10; y <= 30; y++) set_px(30, y, 4);
        lf0 = n_lf;
        rf0 = n_rf;
        go(1, 0, 1, 30, 10);
        @(posedge clk); #1 bus.goMapColumnsL = 1'b1;
        @(posedge clk); #1 bus.goMapColumnsL = 1'b0;
        wait_found(0, lat);
        chk("s4_rows_latency", lat + 2, 63);
        chk("s4_yBottom", int'(bus.yBottom), 30);
        repeat (3) @(negedge clk);
        chk("s4_no_left", n_lf - lf0, 0);
        chk("s4_no_right", n_rf - rf0, 0);

        // reset while a probe is in WAIT
        clear_mem();
        for (int y = 0; y <= 100; y++) set_px(50, y, 5);
        go(1, 0, 0, 50, 0);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("s5_rst_rdEn", int'(bus.rdEn), 0);
        chk("s5_rst_busy", int'(bus.busy), 0);
        chk("s5_rst_yTop", int'(bus.yTop), 0);
        chk("s5_rst_yBottom", int'(bus.yBottom), 0);
        @(posedge clk); #1 resetn = 1'b1;
        go(1, 0, 0, 50, 0);
        wait_found(0, lat);
        chk("s5_after_rst_latency", lat, 303);
        chk("s5_after_rst_yBottom", int'(bus.yBottom), 100);

        // full-width row y=60
        clear_mem();
        for (int x = 0; x < MAX_X; x++) set_px(x, 60, 6);
        go(1, 0, 0, 0, 60);
        wait_found(0, lat);
        chk("s6_rows_latency", lat, 3);
        go(0, 0, 1, 0, 0);
        wait_found(2, lat);
        chk("s6_right_latency", lat, 477);
        chk("s6_xRight", int'(bus.xRight), 159);

        // randomized images and go traffic
        for (int it = 0; it < 16; it++) begin
            wait_idle();
            clear_mem();
            rw = $urandom_range(1, 8);
            rh = $urandom_range(1, 8);
            rx = (it % 4 == 0) ? MAX_X - rw : $urandom_range(0, MAX_X - rw);
            ry = (it % 4 == 1) ? MAX_Y - rh : $urandom_range(0, MAX_Y - rh);
            for (int y = ry; y < ry + rh; y++)
                for (int x = rx; x < rx + rw; x++) set_px(x, y, $urandom_range(1, 7));
            repeat (20) set_px($urandom_range(0, MAX_X - 1), $urandom_range(0, MAX_Y - 1),
                               $urandom_range(0, 7));
            for (int c = 0; c < 150; c++) begin
                @(posedge clk); #1;
                bus.goMapRows     = ($urandom_range(0, 99) < 6);
                bus.goMapColumnsL = ($urandom_range(0, 99) < 6);
                bus.goMapColumnsR = ($urandom_range(0, 99) < 6);
                if ($urandom_range(0, 3) != 0) begin
                    bus.xSeed = 8'(rx);
                    bus.ySeed = 7'(ry);
                end else begin
                    bus.xSeed = 8'($urandom_range(0, MAX_X - 1));
                    bus.ySeed = 7'($urandom_range(0, MAX_Y - 1));
                end
            end
            @(posedge clk); #1;
            bus.goMapRows     = 1'b0;
            bus.goMapColumnsL = 1'b0;
            bus.goMapColumnsR = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
